// File: rtl/tick_sched.sv
// -----------------------------------------------------------------------------
// tick_sched : four-channel programmable tick scheduler with a Wishbone slave
//              register port and a single arbitrated interrupt request.
//
// Each channel down-counts timer tick pulses from a software reload value.
// On expiry it sets a pending flag and, if periodic, reloads; otherwise it
// stops and clears its own enable. A three-state arbiter grants one pending
// channel at a time to the interrupt controller.
//
// Optional feature macro:
//   TICK_SCHED_ROUND_ROBIN_EN - rotate arbiter priority (after a grant to
//                               channel k, channel (k+1) mod 4 is highest).
//                               Undefined: fixed priority, channel 0 highest.
//
// Ports:
//   wb_clk_i   in   1   system clock
//   wb_rst_i   in   1   asynchronous active-high reset
//   tick_i     in   1   one-cycle tick pulse from the timer
//   wb_adr_i   in   3   register address
//   wb_dat_i   in  16   write data
//   wb_dat_o   out 16   read data, valid while wb_ack_o=1
//   wb_we_i    in   1   write enable
//   wb_stb_i   in   1   strobe
//   wb_cyc_i   in   1   cycle
//   wb_ack_o   out  1   one-cycle bus acknowledge
//   irq_o      out  1   level interrupt request
//   irq_vec_o  out  2   granted channel, valid while irq_o=1
//   irq_ack_i  in   1   one-cycle acknowledge from the interrupt controller
//
// Register map: 0-3 RELOAD[n], 4 CTRL {SEL[9:8],PERIODIC[7:4],EN[3:0]},
//               5 STATUS (PENDING[3:0], write-1-to-clear), 6 COUNT[SEL], 7 zero.
// -----------------------------------------------------------------------------
module tick_sched #(
  parameter int CNT_W = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        tick_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        irq_o,
  output logic [1:0]  irq_vec_o,
  input  logic        irq_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] ADR_CTRL   = 3'd4;
  localparam logic [2:0] ADR_STATUS = 3'd5;
  localparam logic [2:0] ADR_COUNT  = 3'd6;

  // Register state
  logic [CNT_W-1:0] reload_q [4];
  logic [CNT_W-1:0] reload_d [4];
  logic [CNT_W-1:0] count_q  [4];
  logic [CNT_W-1:0] count_d  [4];
  logic [3:0]       en_q, en_d;
  logic [3:0]       per_q, per_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       pend_q, pend_d;
  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic             irq_q, irq_d;
  logic             ack_q, ack_d;
  logic [15:0]      dat_q, dat_d;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
  logic [1:0]       rr_q, rr_d;
`endif

  // Decoded bus and channel events
  logic             bus_req;
  logic             wr_en;
  logic             wr_ctrl;
  logic             wr_status;
  logic [3:0]       wr_reload;
  logic [3:0]       en_rise;
  logic [3:0]       fire;
  logic [3:0]       w1c_mask;
  logic [3:0]       ack_clr;
  logic [15:0]      rd_data;
  logic [1:0]       prio_start;

  // Zero-extend a channel-width value onto the 16-bit data bus.
  function automatic logic [15:0] zext(input logic [CNT_W-1:0] v);
    logic [15:0] r;
    r = 16'h0000;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  // First requesting channel found when scanning upward (with wrap) from start.
  function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] w;
    logic [1:0] idx;
    logic       found;
    w     = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && req[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  // Bus request qualification and write decode. A strobe is only taken while
  // no ack is outstanding, which yields the every-other-cycle ack cadence.
  always_comb begin
    bus_req   = wb_stb_i & wb_cyc_i & ~ack_q;
    wr_en     = bus_req & wb_we_i;
    wr_ctrl   = wr_en & (wb_adr_i == ADR_CTRL);
    wr_status = wr_en & (wb_adr_i == ADR_STATUS);
    if (wr_en && !wb_adr_i[2]) begin
      wr_reload = 4'b0001 << wb_adr_i[1:0];
    end else begin
      wr_reload = 4'b0000;
    end
    if (wr_ctrl) begin
      en_rise = wb_dat_i[3:0] & ~en_q;
    end else begin
      en_rise = 4'b0000;
    end
    if (wr_status) begin
      w1c_mask = wb_dat_i[3:0];
    end else begin
      w1c_mask = 4'b0000;
    end
  end

  // Read mux, sampled from pre-write register values at the request edge.
  always_comb begin
    case (wb_adr_i)
      3'd0, 3'd1, 3'd2, 3'd3: rd_data = zext(reload_q[wb_adr_i[1:0]]);
      ADR_CTRL:               rd_data = {6'b000000, sel_q, per_q, en_q};
      ADR_STATUS:             rd_data = {12'h000, pend_q};
      ADR_COUNT:              rd_data = zext(count_q[sel_q]);
      default:                rd_data = 16'h0000;
    endcase
    ack_d = bus_req;
    if (bus_req) begin
      dat_d = rd_data;
    end else begin
      dat_d = dat_q;
    end
  end

  // Channel counters: tick handling first, then software writes override.
  // A RELOAD write suppresses that channel's tick for the cycle entirely.
  always_comb begin
    en_d  = en_q;
    per_d = per_q;
    sel_d = sel_q;
    fire  = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      reload_d[n] = reload_q[n];
      count_d[n]  = count_q[n];
      if (tick_i && en_q[n] && (|reload_q[n]) && !wr_reload[n]) begin
        if (count_q[n] > CNT_W'(1)) begin
          count_d[n] = count_q[n] - CNT_W'(1);
        end else begin
          fire[n] = 1'b1;
          if (per_q[n]) begin
            count_d[n] = reload_q[n];
          end else begin
            count_d[n] = {CNT_W{1'b0}};
            en_d[n]    = 1'b0;
          end
        end
      end else begin
        count_d[n] = count_d[n];
      end
      if (wr_reload[n]) begin
        reload_d[n] = wb_dat_i[CNT_W-1:0];
        count_d[n]  = wb_dat_i[CNT_W-1:0];
      end else if (en_rise[n]) begin
        count_d[n] = reload_q[n];
      end else begin
        reload_d[n] = reload_d[n];
      end
    end
    if (wr_ctrl) begin
      en_d  = wb_dat_i[3:0];
      per_d = wb_dat_i[7:4];
      sel_d = wb_dat_i[9:8];
    end else begin
      sel_d = sel_q;
    end
  end

`ifdef TICK_SCHED_ROUND_ROBIN_EN
  assign prio_start = rr_q;
`else
  assign prio_start = 2'd0;
`endif

  // Pending flags and arbiter FSM. Clears (software and ack) are applied
  // before expiry sets so a same-cycle expiry always survives.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
    rr_d    = rr_q;
`endif
    if ((state_q == ST_REQ) && irq_ack_i) begin
      ack_clr = 4'b0001 << vec_q;
    end else begin
      ack_clr = 4'b0000;
    end
    pend_d = (pend_q & ~w1c_mask & ~ack_clr) | fire;
    case (state_q)
      ST_IDLE: begin
        if (|pend_q) begin
          vec_d   = pick(pend_q, prio_start);
          state_d = ST_REQ;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
          rr_d    = vec_d + 2'd1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // Either the controller acked, or software cleared the granted flag.
        if (irq_ack_i || !pend_d[vec_q]) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    irq_d = (state_d == ST_REQ);
  end

  // State register for all channel, bus and arbiter flops.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int n = 0; n < 4; n++) begin
        reload_q[n] <= {CNT_W{1'b0}};
        count_q[n]  <= {CNT_W{1'b0}};
      end
      en_q    <= 4'b0000;
      per_q   <= 4'b0000;
      sel_q   <= 2'd0;
      pend_q  <= 4'b0000;
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      irq_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= 16'h0000;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
      rr_q    <= 2'd0;
`endif
    end else begin
      for (int n = 0; n < 4; n++) begin
        reload_q[n] <= reload_d[n];
        count_q[n]  <= count_d[n];
      end
      en_q    <= en_d;
      per_q   <= per_d;
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      state_q <= state_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign irq_o     = irq_q;
  assign irq_vec_o = vec_q;

endmodule

// File: tb/tb_tick_sched.sv
// -----------------------------------------------------------------------------
// tb_tick_sched : self-checking bench for tick_sched. A behavioural model of
// the register file, channels and interrupt handshake is stepped once per
// clock alongside the DUT; directed scenarios plus a random phase drive both.
// -----------------------------------------------------------------------------
module tb_tick_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [2:0]  adr;
  logic [15:0] wdat;
  logic [15:0] rdat;
  logic        we, stb, cyc, ack;
  logic        irq;
  logic [1:0]  vec;
  logic        iack;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_rd;

  // Reference model state
  int m_reload [4];
  int m_count  [4];
  bit m_en     [4];
  bit m_per    [4];
  bit m_pend   [4];
  int m_sel;
  int m_mode;   // 0 waiting, 1 requesting, 2 gap
  int m_vec;
  int m_rr;
  bit m_ack;
  int m_dat;

  always #5 clk = ~clk;

  tick_sched dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .tick_i    (tick),
    .wb_adr_i  (adr),
    .wb_dat_i  (wdat),
    .wb_dat_o  (rdat),
    .wb_we_i   (we),
    .wb_stb_i  (stb),
    .wb_cyc_i  (cyc),
    .wb_ack_o  (ack),
    .irq_o     (irq),
    .irq_vec_o (vec),
    .irq_ack_i (iack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      m_reload[n] = 0; m_count[n] = 0; m_en[n] = 0; m_per[n] = 0; m_pend[n] = 0;
    end
    m_sel = 0; m_mode = 0; m_vec = 0; m_rr = 0; m_ack = 0; m_dat = 0;
  endtask

  function automatic int read_reg(int a);
    int v;
    v = 0;
    if (a < 4) v = m_reload[a];
    else if (a == 4) begin
      for (int n = 0; n < 4; n++) v = v + (int'(m_en[n]) << n) + (int'(m_per[n]) << (n + 4));
      v = v + (m_sel << 8);
    end else if (a == 5) begin
      for (int n = 0; n < 4; n++) v = v + (int'(m_pend[n]) << n);
    end else if (a == 6) v = m_count[m_sel];
    return v;
  endfunction

  // One clock of behaviour, from the inputs present at the edge.
  task automatic model_step(input bit t, input bit s, input bit w, input int a,
                            input int d, input bit ia);
    bit req, anyp;
    bit old_en [4];
    bit old_pend [4];
    bit fired [4];
    int win;
    req = s && !m_ack;
    for (int n = 0; n < 4; n++) begin
      old_en[n] = m_en[n]; old_pend[n] = m_pend[n]; fired[n] = 0;
    end
    if (req) m_dat = read_reg(a);
    m_ack = req;
    for (int n = 0; n < 4; n++) begin
      if (t && m_en[n] && m_reload[n] != 0 && !(req && w && a == n)) begin
        if (m_count[n] > 1) m_count[n] = m_count[n] - 1;
        else begin
          fired[n] = 1;
          if (m_per[n]) m_count[n] = m_reload[n];
          else begin m_count[n] = 0; m_en[n] = 0; end
        end
      end
    end
    if (req && w) begin
      if (a < 4) begin
        m_reload[a] = d & 16'hFFFF; m_count[a] = d & 16'hFFFF;
      end else if (a == 4) begin
        for (int n = 0; n < 4; n++) begin
          if (((d >> n) & 1) == 1 && !old_en[n]) m_count[n] = m_reload[n];
          m_en[n]  = ((d >> n) & 1) == 1;
          m_per[n] = ((d >> (n + 4)) & 1) == 1;
        end
        m_sel = (d >> 8) & 3;
      end else if (a == 5) begin
        for (int n = 0; n < 4; n++) if (((d >> n) & 1) == 1) m_pend[n] = 0;
      end
    end
    if (m_mode == 1 && ia) m_pend[m_vec] = 0;
    for (int n = 0; n < 4; n++) if (fired[n]) m_pend[n] = 1;
    if (m_mode == 0) begin
      anyp = 0; win = 0;
`ifdef TICK_SCHED_ROUND_ROBIN_EN
      for (int i = 3; i >= 0; i--) if (old_pend[(m_rr + i) % 4]) begin anyp = 1; win = (m_rr + i) % 4; end
`else
      for (int i = 3; i >= 0; i--) if (old_pend[i]) begin anyp = 1; win = i; end
`endif
      if (anyp) begin m_vec = win; m_mode = 1; m_rr = (win + 1) % 4; end
    end else if (m_mode == 1) begin
      if (ia || !m_pend[m_vec]) m_mode = 2;
    end else m_mode = 0;
  endtask

  task automatic cyc_step(input bit t, input bit s, input bit w, input int a,
                          input int d, input bit ia);
    tick = t; stb = s; cyc = s; we = w; adr = a[2:0]; wdat = d[15:0]; iack = ia;
    @(posedge clk);
    model_step(t, s, w, a, d, ia);
    #1;
    check("irq_o", irq, m_mode == 1);
    check("irq_vec_o", vec, m_vec[1:0]);
    check("wb_ack_o", ack, m_ack);
    if (m_ack) begin
      check("wb_dat_o", rdat, m_dat[15:0]);
      last_rd = rdat;
    end
  endtask

  task automatic idle(input int nc);
    for (int i = 0; i < nc; i++) cyc_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc_step(0, 1, 1, a, d, 0);
    cyc_step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    cyc_step(0, 1, 0, a, 0, 0);
    cyc_step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int cnt_exp [6];
    cnt_exp = '{2, 1, 3, 2, 1, 3};
    last_rd = 16'h0000;
    rst = 1'b1; tick = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    adr = 3'd0; wdat = 16'h0000; iack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_irq", irq, 1'b0);
    check("rst_vec", vec, 2'd0);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", rdat, 16'h0000);
    rst = 1'b0;

    // Periodic channel 0, reload 3
    wr(0, 3);
    wr(4, 16'h0011);
    for (int i = 0; i < 6; i++) begin
      cyc_step(1, 0, 0, 0, 0, 0);
      rd(6);
      check("cnt0_seq", last_rd, cnt_exp[i]);
      if (i == 2) begin
        rd(5);
        check("pend0_set", last_rd[0], 1'b1);
      end
    end
    cyc_step(0, 0, 0, 0, 0, 1);
    wr(4, 0);
    wr(5, 16'h000F);
    idle(3);

    // One-shot channel 1, reload 2
    wr(1, 2);
    wr(4, 16'h0102);
    cyc_step(1, 0, 0, 0, 0, 0);
    idle(1);
    cyc_step(1, 0, 0, 0, 0, 0);
    idle(2);
    rd(4);
    check("en1_clr", last_rd[1], 1'b0);
    rd(6);
    check("cnt1_zero", last_rd, 16'h0000);
    cyc_step(1, 0, 0, 0, 0, 0);
    cyc_step(1, 0, 0, 0, 0, 0);
    rd(6);
    check("cnt1_hold", last_rd, 16'h0000);
    check("os_irq", irq, 1'b1);
    check("os_vec", vec, 2'd1);
    // Software clear of the granted flag while requesting
    cyc_step(0, 1, 1, 5, 2, 0);
    check("swclr_irq", irq, 1'b0);
    idle(3);

    // Arbitration with channels 1 and 3 pending together
    wr(1, 1);
    wr(3, 1);
    wr(4, 16'h000A);
    cyc_step(1, 0, 0, 0, 0, 0);
    idle(3);
    check("arb_vec1", vec, 2'd1);
    cyc_step(0, 0, 0, 0, 0, 1);
    check("gap_lo1", irq, 1'b0);
    idle(1);
    check("gap_lo2", irq, 1'b0);
    idle(1);
    check("arb_irq3", irq, 1'b1);
    check("arb_vec3", vec, 2'd3);
    cyc_step(0, 0, 0, 0, 0, 1);
    idle(3);

    // Expiry colliding with a write-1-clear of the same flag
    wr(0, 1);
    wr(4, 16'h0011);
    cyc_step(1, 1, 1, 5, 1, 0);
    cyc_step(0, 0, 0, 0, 0, 0);
    rd(5);
    check("collide_p0", last_rd[0], 1'b1);
    wr(4, 0);
    wr(5, 16'h000F);
    idle(4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      int a, d;
      a = int'($urandom_range(0, 7));
      if (a < 4) d = int'($urandom_range(0, 4));
      else d = int'($urandom & 32'h0000FFFF);
      cyc_step(($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
               a, d, ($urandom % 3) == 0);
    end

    // Reset while requesting with a bus ack outstanding
    wr(4, 0);
    wr(5, 16'h000F);
    idle(4);
    wr(2, 1);
    wr(4, 16'h0004);
    cyc_step(1, 0, 0, 0, 0, 0);
    idle(3);
    check("pre_rst_irq", irq, 1'b1);
    cyc_step(0, 1, 0, 5, 0, 0);
    #2;
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; tick = 1'b1;
    #1;
    check("arst_irq", irq, 1'b0);
    check("arst_vec", vec, 2'd0);
    check("arst_ack", ack, 1'b0);
    check("arst_dat", rdat, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    tick = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc_step(1, 0, 0, 0, 0, 0);
    rd(4);
    check("post_ctrl", last_rd, 16'h0000);
    rd(2);
    check("post_reload2", last_rd, 16'h0000);
    rd(5);
    check("post_pend", last_rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
